alu_issue_stage: RTL

- Front end of the integer ALU. Accepts raw 32-bit RV64 instructions from fetch over a valid/ready handshake.
- Decodes each instruction into the ALU operand fields: 10-bit {funct3, opcode7}, 5-bit regA, 12-bit regB/immediate and 5-bit regDest.
- Presents the decoded fields to the ALU through a registered valid/ready output slot.
- Holds a 32-entry scoreboard of pending destination registers. Stalls fetch on RAW and WAW hazards until writeback clears the entry.

---
 rtl/alu_issue_stage.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/alu_issue_stage.sv
// Issue stage for the integer ALU: decodes raw RV64 ALU instructions, tracks
// pending destinations in a scoreboard and stalls fetch on RAW/WAW hazards.
module alu_issue_stage #(
  parameter int unsigned NREGS = 32,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [9:0]       out_opcode,
  output logic [4:0]       out_regA,
  output logic [11:0]      out_regB,
  output logic [4:0]       out_regDest,
  output logic             out_illegal,
  input  logic             wb_valid,
  input  logic [4:0]       wb_rd,
  input  logic             flush,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] issue_count
);

  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_IMM_32 = 7'h1b;
  localparam logic [6:0] OP_REG    = 7'h33;
  localparam logic [6:0] OP_REG_32 = 7'h3b;

  logic [6:0]  opcode7;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic        is_rtype;
  logic        legal;
  logic        hazard;
  logic        slot_free;
  logic        accept;
  logic [NREGS-1:0] wb_clr;
  logic [NREGS-1:0] eff_pending;

  logic             out_valid_q,   out_valid_d;
  logic             out_illegal_q, out_illegal_d;
  logic [9:0]       out_opcode_q,  out_opcode_d;
  logic [4:0]       out_rega_q,    out_rega_d;
  logic [11:0]      out_regb_q,    out_regb_d;
  logic [4:0]       out_regdest_q, out_regdest_d;
  logic [NREGS-1:0] pending_q,     pending_d;
  logic [CNT_W-1:0] stall_cnt_q,   stall_cnt_d;
  logic [CNT_W-1:0] issue_cnt_q,   issue_cnt_d;

  // Field extraction and legality of the incoming instruction
  always_comb begin
    opcode7  = in_instr[6:0];
    funct3   = in_instr[14:12];
    funct7   = in_instr[31:25];
    rs1      = in_instr[19:15];
    rs2      = in_instr[24:20];
    rd       = in_instr[11:7];
    is_rtype = (opcode7 == OP_REG) || (opcode7 == OP_REG_32);
    legal    = 1'b0;
    if (opcode7 == OP_IMM) begin
      legal = 1'b1;
    end else if (opcode7 == OP_IMM_32) begin
      legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b101);
    end else if (is_rtype) begin
      legal = (funct7 == 7'b0000000) || (funct7 == 7'b0000001) ||
              (funct7 == 7'b0100000);
    end
  end

  // Hazard check sees this cycle's writeback clear; x0 is never set so never hazards
  always_comb begin
    wb_clr = '0;
    if (wb_valid && (wb_rd != 5'd0)) begin
      wb_clr[wb_rd] = 1'b1;
    end
    eff_pending = pending_q & ~wb_clr;
    hazard      = legal && (eff_pending[rs1] || (is_rtype && eff_pending[rs2]) ||
                            eff_pending[rd]);
    slot_free   = !out_valid_q || out_ready;
    in_ready    = slot_free && !hazard && !flush;
    accept      = in_valid && in_ready;
  end

  // Next-state for the output slot, scoreboard and counters
  always_comb begin
    out_valid_d   = out_valid_q;
    out_illegal_d = out_illegal_q;
    out_opcode_d  = out_opcode_q;
    out_rega_d    = out_rega_q;
    out_regb_d    = out_regb_q;
    out_regdest_d = out_regdest_q;
    pending_d     = eff_pending;
    stall_cnt_d   = stall_cnt_q + CNT_W'(in_valid && !in_ready);
    issue_cnt_d   = issue_cnt_q + CNT_W'(accept);

    if (flush) begin
      out_valid_d = 1'b0;
      pending_d   = '0;
    end else if (accept) begin
      out_valid_d   = 1'b1;
      out_illegal_d = !legal;
      out_opcode_d  = {funct3, opcode7};
      out_rega_d    = rs1;
      out_regb_d    = in_instr[31:20];
      out_regdest_d = rd;
      if (legal && (rd != 5'd0)) begin
        pending_d[rd] = 1'b1;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q   <= 1'b0;
      out_illegal_q <= 1'b0;
      out_opcode_q  <= '0;
      out_rega_q    <= '0;
      out_regb_q    <= '0;
      out_regdest_q <= '0;
      pending_q     <= '0;
      stall_cnt_q   <= '0;
      issue_cnt_q   <= '0;
    end else begin
      out_valid_q   <= out_valid_d;
      out_illegal_q <= out_illegal_d;
      out_opcode_q  <= out_opcode_d;
      out_rega_q    <= out_rega_d;
      out_regb_q    <= out_regb_d;
      out_regdest_q <= out_regdest_d;
      pending_q     <= pending_d;
      stall_cnt_q   <= stall_cnt_d;
      issue_cnt_q   <= issue_cnt_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_illegal = out_illegal_q;
  assign out_opcode  = out_opcode_q;
  assign out_regA    = out_rega_q;
  assign out_regB    = out_regb_q;
  assign out_regDest = out_regdest_q;
  assign stall_count = stall_cnt_q;
  assign issue_count = issue_cnt_q;

endmodule
